// File: rtl/glyph_rom_arbiter.sv
// Two-port arbiter in front of a single asynchronous glyph ROM; returns the
// registered colour index to the granted requester one cycle after the grant.
module glyph_rom_arbiter #(
    parameter int PRIO_A   = 1,
    parameter int MAX_WAIT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       req_a,
    input  logic       sym_a,
    input  logic [4:0] x_a,
    input  logic [4:0] y_a,
    input  logic       req_b,
    input  logic       sym_b,
    input  logic [4:0] x_b,
    input  logic [4:0] y_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       rom_sym,
    output logic [4:0] rom_x,
    output logic [4:0] rom_y,
    input  logic [2:0] rom_data,
    output logic       vld_a,
    output logic [2:0] data_a,
    output logic       vld_b,
    output logic [2:0] data_b
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic       last_b;
    logic [3:0] wait_b;
    logic       pick_b;

    always_comb begin
        gnt_a  = 1'b0;
        gnt_b  = 1'b0;
        pick_b = 1'b0;
        if (rst_n) begin
            if (req_a && req_b) begin
                // Tie: priority mode favours A until B has been starved long enough.
                if (PRIO_A != 0)
                    pick_b = (wait_b == WAIT_LIMIT);
                else
                    pick_b = ~last_b;
                gnt_a = ~pick_b;
                gnt_b = pick_b;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    always_comb begin
        rom_sym = 1'b0;
        rom_x   = '0;
        rom_y   = '0;
        if (gnt_a) begin
            rom_sym = sym_a;
            rom_x   = x_a;
            rom_y   = y_a;
        end else if (gnt_b) begin
            rom_sym = sym_b;
            rom_x   = x_b;
            rom_y   = y_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_a  <= 1'b0;
            vld_b  <= 1'b0;
            data_a <= '0;
            data_b <= '0;
            last_b <= 1'b1;
            wait_b <= '0;
        end else begin
            vld_a <= gnt_a & ~flush;
            vld_b <= gnt_b & ~flush;
            if (gnt_a)
                data_a <= rom_data;
            if (gnt_b)
                data_b <= rom_data;
            if (gnt_b)
                last_b <= 1'b1;
            else if (gnt_a)
                last_b <= 1'b0;
            if (req_b && !gnt_b) begin
                if (wait_b < WAIT_LIMIT)
                    wait_b <= wait_b + 4'd1;
            end else begin
                wait_b <= '0;
            end
        end
    end

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// Randomised and directed checks of glyph_rom_arbiter in priority (index 0)
// and round-robin (index 1) configurations against a behavioural model.
module tb_glyph_rom_arbiter;

    localparam int MAXW = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic [1:0] req_a, sym_a, req_b, sym_b;
    logic [1:0][4:0] x_a, y_a, x_b, y_b;
    logic [1:0] gnt_a, gnt_b, rom_sym, vld_a, vld_b;
    logic [1:0][4:0] rom_x, rom_y;
    logic [1:0][2:0] rom_data, data_a, data_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit   m_last_b [2];
    int   m_wait   [2];
    logic m_vld_a  [2];
    logic m_vld_b  [2];
    logic [2:0] m_data_a [2];
    logic [2:0] m_data_b [2];
    logic obs_a [2];
    logic obs_b [2];

    always #5 clk = ~clk;

    function automatic logic [2:0] rom_fn(input logic s, input logic [4:0] x, input logic [4:0] y);
        logic [2:0] v;
        v = x[2:0] ^ y[2:0];
        return s ? ~v : v;
    endfunction

    assign rom_data[0] = rom_fn(rom_sym[0], rom_x[0], rom_y[0]);
    assign rom_data[1] = rom_fn(rom_sym[1], rom_x[1], rom_y[1]);

    glyph_rom_arbiter #(.PRIO_A(1), .MAX_WAIT(MAXW)) dut_prio (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_a(req_a[0]), .sym_a(sym_a[0]), .x_a(x_a[0]), .y_a(y_a[0]),
        .req_b(req_b[0]), .sym_b(sym_b[0]), .x_b(x_b[0]), .y_b(y_b[0]),
        .gnt_a(gnt_a[0]), .gnt_b(gnt_b[0]),
        .rom_sym(rom_sym[0]), .rom_x(rom_x[0]), .rom_y(rom_y[0]), .rom_data(rom_data[0]),
        .vld_a(vld_a[0]), .data_a(data_a[0]), .vld_b(vld_b[0]), .data_b(data_b[0])
    );

    glyph_rom_arbiter #(.PRIO_A(0), .MAX_WAIT(MAXW)) dut_rr (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_a(req_a[1]), .sym_a(sym_a[1]), .x_a(x_a[1]), .y_a(y_a[1]),
        .req_b(req_b[1]), .sym_b(sym_b[1]), .x_b(x_b[1]), .y_b(y_b[1]),
        .gnt_a(gnt_a[1]), .gnt_b(gnt_b[1]),
        .rom_sym(rom_sym[1]), .rom_x(rom_x[1]), .rom_y(rom_y[1]), .rom_data(rom_data[1]),
        .vld_a(vld_a[1]), .data_a(data_a[1]), .vld_b(vld_b[1]), .data_b(data_b[1])
    );

    // Expected grant {b,a} for instance i from the arbitration rules.
    function automatic logic [1:0] exp_grant(input int i);
        if (!req_a[i] && !req_b[i]) return 2'b00;
        if (req_a[i] && !req_b[i])  return 2'b01;
        if (!req_a[i] && req_b[i])  return 2'b10;
        if (i == 0)                 return (m_wait[i] == MAXW) ? 2'b10 : 2'b01;
        return m_last_b[i] ? 2'b01 : 2'b10;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_last_b[i] = 1'b1;
            m_wait[i]   = 0;
            m_vld_a[i]  = 1'b0;
            m_vld_b[i]  = 1'b0;
            m_data_a[i] = 3'd0;
            m_data_b[i] = 3'd0;
        end
    endtask

    task automatic set_a(input int i, input logic r, input logic s, input logic [4:0] x, input logic [4:0] y);
        req_a[i] = r; sym_a[i] = s; x_a[i] = x; y_a[i] = y;
    endtask

    task automatic set_b(input int i, input logic r, input logic s, input logic [4:0] x, input logic [4:0] y);
        req_b[i] = r; sym_b[i] = s; x_b[i] = x; y_b[i] = y;
    endtask

    // One clock cycle: inputs are already set at the falling edge.
    task automatic step(input logic fl);
        logic [1:0]  g;
        logic [10:0] ea;
        logic [2:0]  rd;
        flush = fl;
        #1;
        for (int i = 0; i < 2; i++) begin
            g = exp_grant(i);
            n_tests++;
            if ({gnt_b[i], gnt_a[i]} !== g) begin
                n_fail++;
                $display("FAIL grant[%0d] got b,a=%b%b expected %b", i, gnt_b[i], gnt_a[i], g);
            end
            ea = g[0] ? {sym_a[i], x_a[i], y_a[i]} : g[1] ? {sym_b[i], x_b[i], y_b[i]} : 11'd0;
            n_tests++;
            if ({rom_sym[i], rom_x[i], rom_y[i]} !== ea) begin
                n_fail++;
                $display("FAIL rom_addr[%0d] got %h expected %h", i, {rom_sym[i], rom_x[i], rom_y[i]}, ea);
            end
            rd = rom_fn(ea[10], ea[9:5], ea[4:0]);
            m_vld_a[i] = g[0] && !fl;
            m_vld_b[i] = g[1] && !fl;
            if (g[0]) m_data_a[i] = rd;
            if (g[1]) m_data_b[i] = rd;
            if (g[1]) m_last_b[i] = 1'b1;
            else if (g[0]) m_last_b[i] = 1'b0;
            if (req_b[i] && !g[1]) m_wait[i] = (m_wait[i] < MAXW) ? m_wait[i] + 1 : MAXW;
            else m_wait[i] = 0;
            obs_a[i] = gnt_a[i];
            obs_b[i] = gnt_b[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({vld_a[i], data_a[i], vld_b[i], data_b[i]} !== {m_vld_a[i], m_data_a[i], m_vld_b[i], m_data_b[i]}) begin
                n_fail++;
                $display("FAIL return[%0d] got vld_a=%b data_a=%0d vld_b=%b data_b=%0d expected %b %0d %b %0d",
                         i, vld_a[i], data_a[i], vld_b[i], data_b[i],
                         m_vld_a[i], m_data_a[i], m_vld_b[i], m_data_b[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_a(i, 1'b0, 1'b0, 5'd0, 5'd0);
            set_b(i, 1'b0, 1'b0, 5'd0, 5'd0);
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({gnt_a[i], gnt_b[i], rom_sym[i], rom_x[i], rom_y[i], vld_a[i], vld_b[i], data_a[i], data_b[i]} !== '0) begin
                n_fail++;
                $display("FAIL reset_state[%0d] got gnt=%b%b rom=%b/%0d/%0d vld=%b%b data=%0d/%0d expected all 0",
                         i, gnt_a[i], gnt_b[i], rom_sym[i], rom_x[i], rom_y[i], vld_a[i], vld_b[i], data_a[i], data_b[i]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        test_reset();
        for (int k = 0; k < 10; k++) begin
            step(1'b0);
            n_tests++;
            if ({gnt_a, gnt_b, vld_a, vld_b, rom_x, rom_y, rom_sym} !== '0) begin
                n_fail++;
                $display("FAIL idle cycle %0d got nonzero outputs gnt=%b/%b vld=%b/%b expected 0", k, gnt_a, gnt_b, vld_a, vld_b);
            end
        end
    endtask

    task automatic test_a_only();
        test_reset();
        for (int i = 0; i < 2; i++) set_a(i, 1'b1, 1'b0, 5'd5, 5'd3);
        for (int k = 0; k < 4; k++) begin
            step(1'b0);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs_a[i] !== 1'b1 || vld_a[i] !== 1'b1 || data_a[i] !== 3'd6 || vld_b[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL a_only[%0d] cycle %0d got gnt_a=%b vld_a=%b data_a=%0d vld_b=%b expected 1 1 6 0",
                             i, k, obs_a[i], vld_a[i], data_a[i], vld_b[i]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        test_reset();
        for (int i = 0; i < 2; i++) begin
            set_a(i, 1'b1, 1'b0, 5'd5, 5'd3);
            set_b(i, 1'b1, 1'b1, 5'd1, 5'd1);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0);
            n_tests++;
            if (obs_a[1] !== (k % 2 == 0) || vld_b[1] !== (k % 2 == 1) ||
                (k % 2 == 1 && data_b[1] !== 3'd7)) begin
                n_fail++;
                $display("FAIL round_robin cycle %0d got gnt_a=%b vld_b=%b data_b=%0d expected gnt_a=%b",
                         k, obs_a[1], vld_b[1], data_b[1], (k % 2 == 0));
            end
            n_tests++;
            if (obs_b[0] !== (k % 4 == 3)) begin
                n_fail++;
                $display("FAIL prio_guard cycle %0d got gnt_b=%b expected %b", k, obs_b[0], (k % 4 == 3));
            end
        end
    endtask

    task automatic test_drop_req_b();
        logic exp_b;
        test_reset();
        set_a(0, 1'b1, 1'b0, 5'd2, 5'd7);
        set_b(0, 1'b1, 1'b0, 5'd4, 5'd4);
        for (int k = 0; k < 7; k++) begin
            req_b[0] = (k != 2);
            step(1'b0);
            exp_b = (k == 6);
            n_tests++;
            if (obs_b[0] !== exp_b) begin
                n_fail++;
                $display("FAIL drop_req_b cycle %0d got gnt_b=%b expected %b", k, obs_b[0], exp_b);
            end
        end
    endtask

    task automatic test_flush();
        test_reset();
        for (int i = 0; i < 2; i++) set_a(i, 1'b1, 1'b0, 5'd5, 5'd3);
        step(1'b1);
        n_tests++;
        if (vld_a[0] !== 1'b0 || data_a[0] !== 3'd6) begin
            n_fail++;
            $display("FAIL flush_cycle got vld_a=%b data_a=%0d expected 0 6", vld_a[0], data_a[0]);
        end
        set_a(0, 1'b1, 1'b1, 5'd7, 5'd2);
        step(1'b0);
        n_tests++;
        if (vld_a[0] !== 1'b1 || data_a[0] !== 3'd2) begin
            n_fail++;
            $display("FAIL after_flush got vld_a=%b data_a=%0d expected 1 2", vld_a[0], data_a[0]);
        end
    endtask

    task automatic test_async_reset();
        test_reset();
        for (int i = 0; i < 2; i++) begin
            set_a(i, 1'b1, 1'b0, 5'd5, 5'd3);
            set_b(i, 1'b1, 1'b1, 5'd1, 5'd1);
        end
        repeat (3) step(1'b0);
        #1;
        n_tests++;
        if (gnt_b !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset_gnt_b got %b expected 11", gnt_b);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({vld_a, vld_b, gnt_a, gnt_b, data_a, data_b} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got vld=%b/%b gnt=%b/%b data_a=%h data_b=%h expected 0",
                     vld_a, vld_b, gnt_a, gnt_b, data_a, data_b);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0);
        n_tests++;
        if (obs_a[0] !== 1'b1 || obs_a[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL first_tie_after_reset got gnt_a=%b%b expected 11", obs_a[1], obs_a[0]);
        end
        repeat (4) step(1'b0);
    endtask

    task automatic test_random();
        test_reset();
        for (int i = 0; i < 2; i++) begin
            set_a(i, 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom));
            set_b(i, 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom));
        end
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 7) == 0);
            // Requests are held until granted, then may change freely.
            for (int i = 0; i < 2; i++) begin
                if (!req_a[i] || obs_a[i])
                    set_a(i, $urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), 5'($urandom));
                if (!req_b[i] || obs_b[i])
                    set_b(i, $urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), 5'($urandom));
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_a_only();
        test_round_robin();
        test_drop_req_b();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
